i2s_rx: RTL
===========

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SAMPLE_W, default 16: captured bits per channel.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on each serial input.
REQ-003 The module SHALL have the following ports:
- clk  in  1  system clock (100 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- i_sclk  in  1  I2S bit clock, asynchronous to clk; at most clk/4.
- i_lrclk  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- i_sdin  in  1  I2S serial data, MSB first.
- i_ready  in  1  consumer accepts the held sample pair.
- i_clr_err  in  1  clears the sticky error flags.
- o_left  out  SAMPLE_W  left sample, two's complement.
- o_right  out  SAMPLE_W  right sample, two's complement.
- o_valid  out  1  sample pair held and available.
- o_overrun  out  1  sticky: a pair was dropped.
- o_frame_err  out  1  sticky: short slot seen.
- o_state  out  2  current FSM state, for PMOD debug.

Function
REQ-004 i_sclk, i_lrclk and i_sdin SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-005 Data and lrclk SHALL be sampled only in the clk cycle in which a synchronized sclk rising edge is detected; falling edges are ignored.
REQ-006 Format SHALL be standard I2S: the first sclk rise after an lrclk change is the delay bit (discarded), and the MSB follows on the next rise.
REQ-007 FSM states:
- SYNC (0): wait for an lrclk 1->0 change seen at an sclk rise, then go to DELAY.
- DELAY (1): discard one bit, then go to SHIFT.
- SHIFT (2): shift i_sdin into the channel shift register, MSB first; after SAMPLE_W bits go to WAIT.
- WAIT (3): ignore extra slot bits; an lrclk change at an sclk rise goes to DELAY.
REQ-008 A 5-bit bit counter SHALL count SHIFT bits, reset to 0 on each DELAY entry.
REQ-009 An lrclk change while in SHIFT SHALL:
- set o_frame_err;
- discard the partial word and any left word pending pairing;
- go to DELAY for the new channel.
REQ-010 A completed left word SHALL be held internally until the right word completes.
REQ-011 Pair delivery on right-word completion:
- if o_valid is low, or i_ready is high in the same cycle, o_left/o_right SHALL load and o_valid SHALL be 1 from the next cycle;
- otherwise the new pair SHALL be dropped, o_left/o_right kept, and o_overrun set.
REQ-012 Latency: o_valid SHALL rise exactly 1 clk after the cycle that detects the sclk rise carrying the right-channel LSB.
REQ-013 o_valid SHALL fall the cycle after o_valid and i_ready are both high, unless a new pair loads in that same cycle.
REQ-014 A right word completing without a held left word (first frame after SYNC or after an error) SHALL be discarded silently.
REQ-015 i_clr_err SHALL clear o_overrun and o_frame_err next cycle; a set event in the same cycle SHALL win.
REQ-016 lrclk samples equal to the previous sampled value SHALL NOT cause a transition.

Reset
REQ-017 On reset, SHALL apply next clk:
- FSM = SYNC, bit counter = 0;
- shift, held-left, o_left and o_right = 0;
- o_valid, o_overrun, o_frame_err = 0;
- synchronizer and history flops = 0.
REQ-018 Reset mid-word SHALL discard the word, with no frame_err, and resynchronize from SYNC.

Structure
REQ-019 The shared audio package SHALL hold the FSM state encoding constants and the default SAMPLE_W (16), shared with the i2s transmitter.
REQ-020 One sub-module, i2s_sync_edge, SHALL provide the synchronizer and rising-edge detector, instantiated for sclk; lrclk and sdin SHALL use its sync path only.

Verification
REQ-021 Bench: sclk = clk/32, 32-bit slots; send L=16'h8001, R=16'h7FFE with i_ready=1 -> o_left=8001, o_right=7FFE, o_valid pulses 1 clk, 1 clk after the right LSB edge is detected.
REQ-022 Bench: three frames with i_ready=0 -> first pair held, o_overrun=1 after frame 2, outputs unchanged; then i_ready=1 -> o_valid drops.
REQ-023 Bench: left slot truncated to 10 bits -> o_frame_err=1, no o_valid that frame, next full frame delivered correctly.
REQ-024 Bench: start mid right slot after reset -> first partial frame produces no o_valid; first complete L/R pair (16'h1234/16'hABCD) delivered.
REQ-025 Bench: reset asserted in SHIFT -> all outputs 0 next cycle, o_state=0.
REQ-026 Bench: i_clr_err and a new overrun in the same cycle -> o_overrun stays 1.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// -----------------------------------------------------------------------------
// i2s_rx_pkg
// Shared audio definitions for the I2S receiver and transmitter: the default
// sample width and the FSM state encoding, which also appears on the debug
// state port.
// -----------------------------------------------------------------------------
package i2s_rx_pkg;

    // Default captured bits per channel.
    localparam int I2S_SAMPLE_W = 16;

    // Frame-tracking states. Encoding is fixed so the debug port is stable.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } i2s_state_e;

endpackage : i2s_rx_pkg

// File: rtl/i2s_sync_edge.sv
// -----------------------------------------------------------------------------
// i2s_sync_edge
// Brings one asynchronous serial line into the clk domain through a chain of
// SYNC_STAGES flops, followed by a history flop for rising-edge detection.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset; clears all flops
//   d_i     in   asynchronous input line
//   sync_o  out  synchronized level (last stage of the chain)
//   rise_o  out  one-cycle pulse when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : i2s_sync_edge

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
// Standard-format I2S receiver. The serial bit clock is oversampled by clk;
// word select and data are sampled only on detected bit-clock rising edges.
// A completed left word is held until its right word arrives, then the pair
// is offered on a valid/ready handshake. Lost pairs and short slots raise
// sticky error flags.
//
// Ports:
//   clk          in   system clock, the only clock
//   reset        in   synchronous active-high reset
//   i_sclk       in   I2S bit clock (asynchronous, <= clk/4)
//   i_lrclk      in   I2S word select (asynchronous), 0 = left, 1 = right
//   i_sdin       in   I2S serial data, MSB first
//   i_ready      in   consumer accepts the held pair
//   i_clr_err    in   clears the sticky error flags
//   o_left       out  left sample, two's complement
//   o_right      out  right sample, two's complement
//   o_valid      out  sample pair held and available
//   o_overrun    out  sticky: a completed pair was dropped
//   o_frame_err  out  sticky: word select changed mid-word
//   o_state      out  current FSM state (debug)
// -----------------------------------------------------------------------------
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int SAMPLE_W    = I2S_SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_sclk,
    input  logic                       i_lrclk,
    input  logic                       i_sdin,
    input  logic                       i_ready,
    input  logic                       i_clr_err,
    output logic signed [SAMPLE_W-1:0] o_left,
    output logic signed [SAMPLE_W-1:0] o_right,
    output logic                       o_valid,
    output logic                       o_overrun,
    output logic                       o_frame_err,
    output logic [1:0]                 o_state
);

    // ---- synchronizers --------------------------------------------------
    logic sclk_s_unused;
    logic sclk_rise;
    logic lrclk_s;
    logic lrclk_rise_unused;
    logic sdin_s;
    logic sdin_rise_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .d_i    (i_sclk),
        .sync_o (sclk_s_unused),
        .rise_o (sclk_rise)
    );

    // Word select and data share the sclk latency so they stay aligned with
    // the detected edge; only their synchronized level is used.
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk    (clk),
        .reset  (reset),
        .d_i    (i_lrclk),
        .sync_o (lrclk_s),
        .rise_o (lrclk_rise_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk    (clk),
        .reset  (reset),
        .d_i    (i_sdin),
        .sync_o (sdin_s),
        .rise_o (sdin_rise_unused)
    );

    // ---- state ----------------------------------------------------------
    i2s_state_e                 state_q;
    logic [4:0]                 bit_cnt_q;
    logic                       chan_q;       // channel of the slot being received
    logic                       lr_prev_q;    // word select at the previous sclk rise
    logic signed [SAMPLE_W-1:0] shift_q;
    logic signed [SAMPLE_W-1:0] held_left_q;
    logic                       held_vld_q;
    logic signed [SAMPLE_W-1:0] left_q;
    logic signed [SAMPLE_W-1:0] right_q;
    logic                       valid_q;
    logic                       overrun_q;
    logic                       frame_err_q;

    // ---- per-edge decode ------------------------------------------------
    logic                       lr_chg;
    logic                       last_bit;
    logic signed [SAMPLE_W-1:0] word_d;
    logic                       right_done;
    logic                       load_pair;
    logic                       overrun_set;
    logic                       frame_err_set;
    logic                       overrun_d;
    logic                       frame_err_d;

    assign lr_chg   = (lrclk_s != lr_prev_q);
    assign last_bit = (bit_cnt_q == 5'(SAMPLE_W - 1));
    assign word_d   = {shift_q[SAMPLE_W-2:0], sdin_s};

    // A right word only forms a pair if its left partner is still held.
    assign right_done    = sclk_rise && (state_q == ST_SHIFT) && !lr_chg &&
                           last_bit && chan_q && held_vld_q;
    assign load_pair     = right_done && (!valid_q || i_ready);
    assign overrun_set   = right_done && valid_q && !i_ready;
    assign frame_err_set = sclk_rise && (state_q == ST_SHIFT) && lr_chg;

    // Set events take priority over a simultaneous clear.
    assign overrun_d   = overrun_set   | (overrun_q   & ~i_clr_err);
    assign frame_err_d = frame_err_set | (frame_err_q & ~i_clr_err);

    // ---- FSM and output registers ---------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            bit_cnt_q   <= '0;
            chan_q      <= 1'b0;
            lr_prev_q   <= 1'b0;
            shift_q     <= '0;
            held_left_q <= '0;
            held_vld_q  <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (sclk_rise) begin
                lr_prev_q <= lrclk_s;
                case (state_q)
                    // Lock on the start of a left slot only.
                    ST_SYNC: begin
                        if (lr_chg && !lrclk_s) begin
                            state_q   <= ST_DELAY;
                            chan_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end
                    end
                    // The rise that revealed the word-select change was the
                    // I2S delay bit and has been discarded; this rise carries
                    // the MSB, which is counted as the first shifted bit.
                    ST_DELAY: begin
                        state_q   <= ST_SHIFT;
                        shift_q   <= word_d;
                        bit_cnt_q <= 5'd1;
                    end
                    ST_SHIFT: begin
                        if (lr_chg) begin
                            // Short slot: drop the partial word and any
                            // unpaired left word, restart on the new channel.
                            state_q    <= ST_DELAY;
                            chan_q     <= lrclk_s;
                            bit_cnt_q  <= '0;
                            shift_q    <= '0;
                            held_vld_q <= 1'b0;
                        end else begin
                            shift_q   <= word_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (last_bit) begin
                                state_q <= ST_WAIT;
                                if (!chan_q) begin
                                    held_left_q <= word_d;
                                    held_vld_q  <= 1'b1;
                                end else begin
                                    held_vld_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    // Padding bits of the slot are ignored.
                    ST_WAIT: begin
                        if (lr_chg) begin
                            state_q   <= ST_DELAY;
                            chan_q    <= lrclk_s;
                            bit_cnt_q <= '0;
                        end
                    end
                    default: state_q <= ST_SYNC;
                endcase
            end

            if (load_pair) begin
                left_q  <= held_left_q;
                right_q <= word_d;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end

            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_left      = left_q;
    assign o_right     = right_q;
    assign o_valid     = valid_q;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
    assign o_state     = state_q;

endmodule : i2s_rx
